// File: rtl/barrel_pkg.sv
// Shared types and helpers for the sequential barrel un-shifter.
// Holds the FSM state encoding, the default data width and a single-step
// right-rotate helper usable for any width up to MaxWidth.
package barrel_pkg;

    localparam int unsigned DefaultWidth = 4;
    // Upper bound on the data width supported by rotr1.
    localparam int unsigned MaxWidth     = 64;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRot  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Rotate the low `width` bits of `word` right by one position.
    // Bits above `width` must be zero on entry and stay zero on exit.
    function automatic logic [MaxWidth-1:0] rotr1(input logic [MaxWidth-1:0] word,
                                                  input int unsigned         width);
        logic [MaxWidth-1:0] lsb_ext;
        lsb_ext = MaxWidth'(word[0]);
        return (word >> 1) | (lsb_ext << (width - 1));
    endfunction

endpackage

// File: rtl/seq_barrel_unshifter_if.sv
// Handshake bundle for the sequential barrel un-shifter.
// slave: the un-shifter itself; master: the upstream source / downstream sink.
interface seq_barrel_unshifter_if
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SHW   = $clog2(WIDTH)
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shift;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_shift,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output busy
    );

    modport master (
        output in_valid,
        output in_data,
        output in_shift,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  busy
    );

endinterface

// File: rtl/seq_barrel_unshifter.sv
// Sequential barrel un-shifter: captures a word and rotates it right by
// in_shift positions, one position per clock, undoing an upstream
// left-rotate barrel shifter. One transaction in flight at a time.
//
// Optional build macro SEQ_BARREL_UNSHIFTER_FAST_DONE_EN: shortens latency
// by folding the final rotate into the transition to DONE (and skipping ROT
// entirely for a zero shift). Results are identical in both builds.
//
// WIDTH must be a power of two, at least 2 and at most barrel_pkg::MaxWidth.
module seq_barrel_unshifter
    import barrel_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic                  clk,
    input logic                  rst,
    seq_barrel_unshifter_if.slave bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] data_rot;

    assign data_rot = WIDTH'(rotr1(MaxWidth'(data_q), WIDTH));

    // Next-state logic: accept in IDLE, count down while rotating, hold in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    data_d = bus.in_data;
                    cnt_d  = bus.in_shift;
`ifdef SEQ_BARREL_UNSHIFTER_FAST_DONE_EN
                    state_d = (bus.in_shift == '0) ? StDone : StRot;
`else
                    state_d = StRot;
`endif
                end
            end
            StRot: begin
`ifdef SEQ_BARREL_UNSHIFTER_FAST_DONE_EN
                // Last rotate and exit share one edge.
                if (cnt_q != '0) begin
                    data_d = data_rot;
                    cnt_d  = cnt_q - 1'b1;
                end
                if (cnt_q <= SHW'(1)) begin
                    state_d = StDone;
                end
`else
                if (cnt_q != '0) begin
                    data_d = data_rot;
                    cnt_d  = cnt_q - 1'b1;
                end else begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                // Input is ignored here; re-accept only happens back in IDLE.
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, data and count registers; reset aborts any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.out_data  = data_q;
    assign bus.busy      = (state_q == StRot) || (state_q == StDone);

endmodule

// File: doc/seq_barrel_unshifter.md
Name: seq_barrel_unshifter

Overview:
Iterative right-rotator. It undoes the combinational left-rotate barrel shifter by rotating a captured word right by `in_shift` positions, one position per clock. It sits downstream of the left-rotate barrel shifter and recovers the original word. Valid/ready handshake on both input and output; one transaction in flight at a time.

Parameters:
- WIDTH, 4: data width; must be a power of two, ≥2.
- SHW, $clog2(WIDTH) = 2: width of the shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  request present
- in_ready  output  1  block can accept; high only in IDLE
- in_data  input  WIDTH  word to un-rotate
- in_shift  input  SHW  right-rotate amount, 0..WIDTH-1
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  rotated-right result
- busy  output  1  high in ROT or DONE

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, data_reg=0, cnt=0.
  - in_ready=1 after reset; out_valid=0, out_data=0, busy=0.
  - Reset asserted mid-operation aborts the transaction; no partial result is emitted.
- States: IDLE, ROT, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: data_reg<=in_data, cnt<=in_shift, go to ROT.
- ROT:
  - If cnt!=0: data_reg<={data_reg[0], data_reg[WIDTH-1:1]}, cnt<=cnt-1, stay in ROT.
  - If cnt==0: go to DONE; data_reg is unchanged.
- DONE:
  - out_valid=1 and out_data=data_reg.
  - On out_ready at an edge, go to IDLE.
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable indefinitely.
- Latency: accept at edge k gives out_valid high after edge k+in_shift+1.
- Throughput: one result per in_shift+3 cycles minimum (includes the return to IDLE). No same-cycle re-accept in DONE.
- Input handshake while busy:
  - in_valid is ignored while in_ready=0; in_data and in_shift are not sampled.
  - The source must hold its request until it sees in_ready.
- out_data is the registered data_reg value. It is only meaningful while out_valid=1.
- Arithmetic:
  - cnt is SHW bits, unsigned, and counts down only; it never wraps, because it exits at 0.
  - in_shift=0 gives out_data=in_data after one ROT cycle.
  - in_shift=WIDTH-1 is the maximum.
- Simultaneous events:
  - out_ready high in any state other than DONE has no effect.
  - in_valid in DONE is ignored even if out_ready is also high.

Optional Feature:
- Macro: SEQ_BARREL_UNSHIFTER_FAST_DONE_EN.
- Defined:
  - Accept with in_shift=0 goes directly IDLE→DONE (data_reg<=in_data); latency is 1.
  - Otherwise ROT performs the final rotate and moves to DONE in the same edge when cnt==1.
  - Latency is in_shift edges.
- Undefined: the base behaviour above applies (latency in_shift+1).
- Output values are identical in both builds; only timing differs.

Decomposition:
- Shared package `barrel_pkg`:
  - state enum (IDLE, ROT, DONE)
  - default WIDTH constant
  - function rotr1(word) for a single-position right rotate
- Single module; no sub-module. The rotate is one line using rotr1.

Test Plan:
- Basic un-rotate, in_data=1101, out_ready=1:
  - in_shift=00 → 1101
  - in_shift=01 → 1110
  - in_shift=10 → 0111
  - in_shift=11 → 1011
  - out_valid timing: base build, after edge k+in_shift+1; FAST build, after edge k+max(in_shift,1), and k+1 for shift 0.
- Round-trip, inputs equal to the left-rotate shifter's outputs:
  - 1011 shift 01 → 1101
  - 0101 shift 01 → 1010
  - 1010 shift 10 → 1010
  - 0101 shift 11 → 1010
- Backpressure: 1010 shift 01 with out_ready=0 for 5 cycles → out_valid=1 and out_data=0101 stable for all 5 cycles; after out_ready=1, IDLE and in_ready=1 on the next cycle.
- Busy input ignored: accept 1101 shift 11, then change in_data to 0000 with in_valid=1 while busy → result is 1011; the second word is accepted only after return to IDLE.
- Async reset mid-ROT: accept 1101 shift 11, assert rst between edges two cycles later → immediately out_valid=0, busy=0, in_ready=1, out_data=0000; no result emitted after release.
- Back-to-back: two requests held on in_valid (1101/01, then 1010/11) → results 1110 then 0101, in order, with no drop or duplicate.
